bcd_updown_counter: RTL and testbench

Parametrised N-digit BCD counter with synchronous clear, parallel load, count enable, up/down direction, and a wrap or saturate mode. It is the next generation of the team's 2-digit load-able BCD counter. It is used for display and timebase counters throughout the lab designs. Outputs are registered per-digit BCD values plus terminal-count and load-error flags.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_digit_cell.sv | 44 ++++
 rtl/bcd_updown_counter.sv | 117 +++++++++++
 tb/tb_bcd_updown_counter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD types, limits and helpers for the BCD counter family.
//   bcd_digit_t : one packed BCD digit (4 bits)
//   BCD_MAX/MIN : legal digit range limits
//   is_bcd()    : 1 when a 4-bit value is a legal BCD digit
package bcd_pkg;

  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic logic is_bcd(input bcd_digit_t value);
    return (value <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// Single BCD digit register with clear, sanitised load and up/down step.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   clear               : synchronous clear to 0 (highest priority)
//   load, load_value    : synchronous load; illegal digits load as 0
//   step_en, up         : step one position in the given direction
//   digit               : registered digit value
//   at_max_c, at_min_c  : combinational flags, digit == 9 / digit == 0
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       load,
  input  bcd_digit_t load_value,
  input  logic       step_en,
  input  logic       up,
  output bcd_digit_t digit,
  output logic       at_max_c,
  output logic       at_min_c
);

  assign at_max_c = (digit == BCD_MAX);
  assign at_min_c = (digit == BCD_MIN);

  // Digit register: clear > load > step > hold; wrap keeps the digit in 0..9.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= BCD_MIN;
    end else if (clear) begin
      digit <= BCD_MIN;
    end else if (load) begin
      digit <= is_bcd(load_value) ? load_value : BCD_MIN;
    end else if (step_en) begin
      if (up) begin
        digit <= at_max_c ? BCD_MIN : bcd_digit_t'(digit + 4'd1);
      end else begin
        digit <= at_min_c ? BCD_MAX : bcd_digit_t'(digit - 4'd1);
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// N-digit BCD up/down counter with clear, load, enable and wrap/saturate.
// Ports:
//   CLOCK_I, RESETN_I : clock, async active-low reset
//   CLEAR_I           : synchronous clear (highest priority)
//   LOAD_I            : synchronous parallel load of LOAD_VALUE_I
//   LOAD_VALUE_I      : per-digit load value, digit 0 least significant
//   ENABLE_I          : one step per enabled cycle
//   UP_DOWN_I         : 1 = up, 0 = down
//   BCD_COUNT_O       : registered count, one BCD digit per element
//   TERMINAL_O        : registered wrap / saturation-blocked event flag
//   LOAD_ERROR_O      : registered, last load held a digit > 9
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter bit          SATURATE   = 1'b0
) (
  input  logic                             CLOCK_I,
  input  logic                             RESETN_I,
  input  logic                             CLEAR_I,
  input  logic                             LOAD_I,
  input  logic [NUM_DIGITS-1:0][BCD_W-1:0] LOAD_VALUE_I,
  input  logic                             ENABLE_I,
  input  logic                             UP_DOWN_I,
  output logic [NUM_DIGITS-1:0][BCD_W-1:0] BCD_COUNT_O,
  output logic                             TERMINAL_O,
  output logic                             LOAD_ERROR_O
);

  logic [NUM_DIGITS-1:0][BCD_W-1:0] count_q;
  logic [NUM_DIGITS-1:0]            at_max;
  logic [NUM_DIGITS-1:0]            at_min;
  logic [NUM_DIGITS-1:0]            carry_en_c;
  logic [NUM_DIGITS-1:0]            borrow_en_c;
  logic [NUM_DIGITS-1:0]            step_en_c;
  logic                             all_max_c;
  logic                             all_min_c;
  logic                             at_limit_c;
  logic                             blocked_c;
  logic                             load_err_c;

  // Ripple enables: a digit steps once every lower digit sits at its limit.
  always_comb begin
    logic carry_acc;
    logic borrow_acc;
    carry_acc   = 1'b1;
    borrow_acc  = 1'b1;
    carry_en_c  = '0;
    borrow_en_c = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      carry_en_c[i]  = carry_acc;
      borrow_en_c[i] = borrow_acc;
      carry_acc      = carry_acc & at_max[i];
      borrow_acc     = borrow_acc & at_min[i];
    end
    all_max_c = carry_acc;
    all_min_c = borrow_acc;
  end

  // Terminal value depends on the direction of the step being requested.
  assign at_limit_c = UP_DOWN_I ? all_max_c : all_min_c;
  assign blocked_c  = SATURATE ? at_limit_c : 1'b0;

  always_comb begin
    step_en_c = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      step_en_c[i] = ENABLE_I & ~blocked_c &
                     (UP_DOWN_I ? carry_en_c[i] : borrow_en_c[i]);
    end
  end

  // Any illegal digit in the load word raises the load error.
  always_comb begin
    load_err_c = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!is_bcd(LOAD_VALUE_I[i])) begin
        load_err_c = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk        (CLOCK_I),
      .rst_n      (RESETN_I),
      .clear      (CLEAR_I),
      .load       (LOAD_I),
      .load_value (LOAD_VALUE_I[g]),
      .step_en    (step_en_c[g]),
      .up         (UP_DOWN_I),
      .digit      (count_q[g]),
      .at_max_c   (at_max[g]),
      .at_min_c   (at_min[g])
    );
  end

  assign BCD_COUNT_O = count_q;

  // An enabled step from the limit either wraps or is blocked; both flag TERMINAL_O.
  always_ff @(posedge CLOCK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      TERMINAL_O   <= 1'b0;
      LOAD_ERROR_O <= 1'b0;
    end else if (CLEAR_I) begin
      TERMINAL_O   <= 1'b0;
      LOAD_ERROR_O <= 1'b0;
    end else if (LOAD_I) begin
      TERMINAL_O   <= 1'b0;
      LOAD_ERROR_O <= load_err_c;
    end else if (ENABLE_I) begin
      TERMINAL_O   <= at_limit_c;
    end else begin
      TERMINAL_O   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for bcd_updown_counter: three instances
//   a: 4 digits wrap, b: 4 digits saturate, c: 1 digit wrap.
module tb_bcd_updown_counter;

  typedef struct {
    logic [15:0] cnt;
    logic        term;
    logic        err;
    string       nm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr [3];
  logic        ld  [3];
  logic        en  [3];
  logic        up  [3];
  logic [15:0] lv  [3];

  logic [15:0] cnt_a, cnt_b;
  logic [3:0]  cnt_c;
  logic        term_a, term_b, term_c;
  logic        err_a, err_b, err_c;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t m0, m1, m2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bcd_updown_counter #(.NUM_DIGITS(4), .SATURATE(1'b0)) u_a (
    .CLOCK_I(clk), .RESETN_I(rst_n), .CLEAR_I(clr[0]), .LOAD_I(ld[0]),
    .LOAD_VALUE_I(lv[0]), .ENABLE_I(en[0]), .UP_DOWN_I(up[0]),
    .BCD_COUNT_O(cnt_a), .TERMINAL_O(term_a), .LOAD_ERROR_O(err_a));

  bcd_updown_counter #(.NUM_DIGITS(4), .SATURATE(1'b1)) u_b (
    .CLOCK_I(clk), .RESETN_I(rst_n), .CLEAR_I(clr[1]), .LOAD_I(ld[1]),
    .LOAD_VALUE_I(lv[1]), .ENABLE_I(en[1]), .UP_DOWN_I(up[1]),
    .BCD_COUNT_O(cnt_b), .TERMINAL_O(term_b), .LOAD_ERROR_O(err_b));

  bcd_updown_counter #(.NUM_DIGITS(1), .SATURATE(1'b0)) u_c (
    .CLOCK_I(clk), .RESETN_I(rst_n), .CLEAR_I(clr[2]), .LOAD_I(ld[2]),
    .LOAD_VALUE_I(lv[2][3:0]), .ENABLE_I(en[2]), .UP_DOWN_I(up[2]),
    .BCD_COUNT_O(cnt_c), .TERMINAL_O(term_c), .LOAD_ERROR_O(err_c));

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue the state expected after the next edge.
  task automatic op(input int d, input logic c, input logic l, input logic [15:0] v,
                    input logic e, input logic u, input logic [15:0] xc,
                    input logic xt, input logic xe, input string nm);
    exp_t x;
    @(negedge clk);
    clr[d] = c;
    ld[d]  = l;
    lv[d]  = v;
    en[d]  = e;
    up[d]  = u;
    x.cnt  = xc;
    x.term = xt;
    x.err  = xe;
    x.nm   = nm;
    case (d)
      0:       q0.push_back(x);
      1:       q1.push_back(x);
      default: q2.push_back(x);
    endcase
  endtask

  // Monitors: compare each queued expectation just after the edge it belongs to.
  always @(posedge clk) begin
    #1;
    if (q0.size() != 0) begin
      m0 = q0.pop_front();
      chk({m0.nm, ".cnt"},  cnt_a,            m0.cnt);
      chk({m0.nm, ".term"}, {15'b0, term_a},  {15'b0, m0.term});
      chk({m0.nm, ".err"},  {15'b0, err_a},   {15'b0, m0.err});
    end
    if (q1.size() != 0) begin
      m1 = q1.pop_front();
      chk({m1.nm, ".cnt"},  cnt_b,            m1.cnt);
      chk({m1.nm, ".term"}, {15'b0, term_b},  {15'b0, m1.term});
      chk({m1.nm, ".err"},  {15'b0, err_b},   {15'b0, m1.err});
    end
    if (q2.size() != 0) begin
      m2 = q2.pop_front();
      chk({m2.nm, ".cnt"},  {12'b0, cnt_c},   m2.cnt);
      chk({m2.nm, ".term"}, {15'b0, term_c},  {15'b0, m2.term});
      chk({m2.nm, ".err"},  {15'b0, err_c},   {15'b0, m2.err});
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      clr[i] = 1'b0; ld[i] = 1'b0; en[i] = 1'b0; up[i] = 1'b1; lv[i] = 16'h0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst.a.cnt",  cnt_a, 16'h0);
    chk("rst.a.flags", {14'b0, term_a, err_a}, 16'h0);
    chk("rst.b.cnt",  cnt_b, 16'h0);
    chk("rst.c.cnt",  {12'b0, cnt_c}, 16'h0);

    // Carry and borrow across several digits
    op(0, 0, 1, 16'h0199, 0, 1, 16'h0199, 0, 0, "t1.load");
    op(0, 0, 0, 16'h0,    1, 1, 16'h0200, 0, 0, "t1.up");
    op(0, 0, 0, 16'h0,    1, 0, 16'h0199, 0, 0, "t1.down");
    op(0, 0, 0, 16'h0,    0, 0, 16'h0199, 0, 0, "t1.hold");

    // Wrap in both directions with one-cycle terminal pulse
    op(0, 0, 1, 16'h9999, 0, 1, 16'h9999, 0, 0, "t2.load9999");
    op(0, 0, 0, 16'h0,    1, 1, 16'h0000, 1, 0, "t2.wrap_up");
    op(0, 0, 0, 16'h0,    1, 1, 16'h0001, 0, 0, "t2.after_wrap");
    op(0, 0, 1, 16'h0000, 0, 0, 16'h0000, 0, 0, "t2.load0000");
    op(0, 0, 0, 16'h0,    1, 0, 16'h9999, 1, 0, "t2.wrap_down");
    op(0, 0, 0, 16'h0,    0, 0, 16'h9999, 0, 0, "t2.hold");

    // Illegal load digits are zeroed and flagged until the next load
    op(0, 0, 1, 16'hA3F5, 0, 1, 16'h0305, 0, 1, "t4.bad_load");
    op(0, 0, 0, 16'h0,    0, 1, 16'h0305, 0, 1, "t4.err_hold");
    op(0, 0, 0, 16'h0,    1, 1, 16'h0306, 0, 1, "t4.err_count");
    op(0, 0, 1, 16'h1234, 0, 1, 16'h1234, 0, 0, "t4.good_load");

    // Clear beats load and enable
    op(0, 0, 1, 16'hA321, 0, 1, 16'h0321, 0, 1, "t5.bad_load");
    op(0, 1, 1, 16'h9999, 1, 1, 16'h0000, 0, 0, "t5.clear");
    op(0, 0, 0, 16'h0,    1, 1, 16'h0001, 0, 0, "t5.up1");
    op(0, 0, 1, 16'h0A05, 0, 1, 16'h0005, 0, 1, "t5.bad_load2");
    op(0, 0, 0, 16'h0,    1, 1, 16'h0006, 0, 1, "t5.up2");
    // Async reset between edges while counting
    @(posedge clk);
    #3;
    chk("t5.pre_rst.cnt", cnt_a, 16'h0006);
    chk("t5.pre_rst.err", {15'b0, err_a}, 16'h1);
    rst_n = 1'b0;
    #1;
    chk("t5.rst.cnt",  cnt_a, 16'h0);
    chk("t5.rst.term", {15'b0, term_a}, 16'h0);
    chk("t5.rst.err",  {15'b0, err_a}, 16'h0);
    en[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Saturation at both limits
    op(1, 0, 1, 16'h9998, 0, 1, 16'h9998, 0, 0, "t3.load");
    op(1, 0, 0, 16'h0,    1, 1, 16'h9999, 0, 0, "t3.up1");
    op(1, 0, 0, 16'h0,    1, 1, 16'h9999, 1, 0, "t3.up2");
    op(1, 0, 0, 16'h0,    1, 1, 16'h9999, 1, 0, "t3.up3");
    op(1, 0, 0, 16'h0,    1, 0, 16'h9998, 0, 0, "t3.down");
    op(1, 0, 1, 16'h0000, 0, 0, 16'h0000, 0, 0, "t3.load0");
    op(1, 0, 0, 16'h0,    1, 0, 16'h0000, 1, 0, "t3.sat_down");
    op(1, 0, 0, 16'h0,    1, 1, 16'h0001, 0, 0, "t3.away");
    op(1, 0, 0, 16'h0,    0, 1, 16'h0001, 0, 0, "t3.hold");

    // Single decade counter
    for (int k = 0; k < 12; k++) begin
      int v;
      v = (k + 1) % 10;
      op(2, 0, 0, 16'h0, 1, 1, 16'(v), (v == 0), 0, "t6.up");
    end
    for (int k = 0; k < 5; k++) begin
      op(2, 0, 0, 16'h0, 0, 1, 16'h0002, 0, 0, "t6.hold");
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 16'(q0.size() + q1.size() + q2.size()), 16'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
